audio_mixer_nch: RTL

AUDIO_MIXER_NCH -- requirements
Module: audio_mixer_nch

---
 rtl/audio_mixer_nch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/audio_mixer_nch.sv
// N-channel PCM mixer with per-channel 4-bit left/right volumes, sequential
// multiply-accumulate, output saturation and first-order sigma-delta DACs.
module audio_mixer_nch #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int OUTW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_stb,
    input  logic [NCH*W-1:0]  ch_data,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [7:0]        cfg_data,
    output logic [OUTW-1:0]   mix_l,
    output logic [OUTW-1:0]   mix_r,
    output logic              mix_valid,
    output logic              overrun,
    output logic              audio_left,
    output logic              audio_right
);

    localparam int AW = W + 4 + $clog2(NCH + 1);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (AW > OUTW) ? AW : OUTW + 1;
    localparam logic [CW-1:0] MIX_MAX = CW'((2 ** OUTW) - 1);

    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

    state_t        state;
    logic [3:0]    vol_l   [NCH];
    logic [3:0]    vol_r   [NCH];
    logic [3:0]    snap_vl [NCH];
    logic [3:0]    snap_vr [NCH];
    logic [W-1:0]  snap_s  [NCH];
    logic [IW-1:0] idx;
    logic [AW-1:0] acc_l;
    logic [AW-1:0] acc_r;
    logic [AW-1:0] prod_l;
    logic [AW-1:0] prod_r;
    logic [W-1:0]  cur_s;
    logic [3:0]    cur_vl;
    logic [3:0]    cur_vr;
    logic [CW-1:0] scaled_l;
    logic [CW-1:0] scaled_r;
    logic [OUTW:0] dac_l;
    logic [OUTW:0] dac_r;

    // Channel select for the current accumulation step (snapshot copies only).
    always_comb begin
        cur_s  = '0;
        cur_vl = '0;
        cur_vr = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) begin
                cur_s  = snap_s[i];
                cur_vl = snap_vl[i];
                cur_vr = snap_vr[i];
            end
        end
        prod_l   = AW'(cur_s) * AW'(cur_vl);
        prod_r   = AW'(cur_s) * AW'(cur_vr);
        scaled_l = CW'(acc_l >> 4);
        scaled_r = CW'(acc_r >> 4);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
            mix_l     <= '0;
            mix_r     <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                vol_l[i]   <= '1;
                vol_r[i]   <= '1;
                snap_vl[i] <= '0;
                snap_vr[i] <= '0;
                snap_s[i]  <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_we && (cfg_addr == 3'(i))) begin
                    vol_l[i] <= cfg_data[7:4];
                    vol_r[i] <= cfg_data[3:0];
                end
            end
            case (state)
                IDLE: begin
                    if (sample_stb) begin
                        for (int unsigned i = 0; i < NCH; i++) begin
                            snap_s[i]  <= ch_data[i*W +: W];
                            snap_vl[i] <= vol_l[i];
                            snap_vr[i] <= vol_r[i];
                        end
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (sample_stb) overrun <= 1'b1;
                    acc_l <= acc_l + prod_l;
                    acc_r <= acc_r + prod_r;
                    if (idx == IW'(NCH - 1)) begin
                        state <= SAT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SAT: begin
                    // A strobe coinciding with the return to IDLE is still busy.
                    if (sample_stb) overrun <= 1'b1;
                    mix_l     <= (scaled_l > MIX_MAX) ? '1 : scaled_l[OUTW-1:0];
                    mix_r     <= (scaled_r > MIX_MAX) ? '1 : scaled_r[OUTW-1:0];
                    mix_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dac_l <= '0;
            dac_r <= '0;
        end else begin
            dac_l <= {1'b0, dac_l[OUTW-1:0]} + {1'b0, mix_l};
            dac_r <= {1'b0, dac_r[OUTW-1:0]} + {1'b0, mix_r};
        end
    end

    assign audio_left  = dac_l[OUTW];
    assign audio_right = dac_r[OUTW];

endmodule
